// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch controller.
// Contents:
//   state_t   - FSM state encoding (IDLE, RUN, DONE)
//   COND_*    - cond_sel encodings for conditional jumps and calls
//   cond_eval - picks the jump condition from the registered flags
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] COND_ALW  = 2'b00;
  localparam logic [1:0] COND_ZERO = 2'b01;
  localparam logic [1:0] COND_PARI = 2'b10;
  localparam logic [1:0] COND_SC   = 2'b11;

  function automatic logic cond_eval(input logic [1:0] sel,
                                     input logic       zero_q,
                                     input logic       pari_q,
                                     input logic       sc_q);
    case (sel)
      COND_ZERO: cond_eval = zero_q;
      COND_PARI: cond_eval = pari_q;
      COND_SC:   cond_eval = sc_q;
      default:   cond_eval = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/fetch_ctrl_ret_stack.sv
// Hardware return-address stack for call/return.
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-low reset, empties the stack
//   clr       - synchronous empty (used when a new run starts)
//   push      - write push_data on top (ignored when full)
//   pop       - discard top entry (ignored when empty)
//   push_data - return address to store
//   pop_data  - current top entry (valid when !empty)
//   full      - SD entries held
//   empty     - no entries held
module ret_stack #(
  parameter int D  = 12,
  parameter int SD = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int SPW = $clog2(SD + 1);
  localparam int IW  = (SD > 1) ? $clog2(SD) : 1;

  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_m1;
  logic [D-1:0]   mem [0:SD-1];

  assign sp_m1    = sp - 1'b1;
  assign full     = (sp == SPW'(SD));
  assign empty    = (sp == '0);
  assign pop_data = mem[sp_m1[IW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

  // Entries carry no reset; only sp decides which ones are meaningful.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) begin
      mem[sp[IW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: program counter, req/done run handshake, conditional
// relative/absolute jumps, and call/return through a return-address stack.
// Ports:
//   clk, reset            - clock (rising edge), async active-low reset
//   req                   - start request, sampled in IDLE/DONE
//   halt                  - halt instruction at current PC
//   reljump_en/absjump_en - relative / absolute jump requests
//   call_en/ret_en        - call (push pc+1, jump to target) / return
//   cond_sel              - 00 always, 01 zero, 10 parity, 11 carry
//   zero_q/pari_q/sc_q    - registered ALU flags
//   rel_off               - two's-complement relative offset
//   target                - absolute target from PC_LUT
//   prog_ctr              - current program counter
//   run/done              - state RUN / state DONE
//   stk_err               - sticky stack overflow/underflow flag
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          D        = 12,
  parameter int          SD       = 4,
  parameter int unsigned START_PC = 0,
  parameter int unsigned END_PC   = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                halt,
  input  logic                reljump_en,
  input  logic                absjump_en,
  input  logic                call_en,
  input  logic                ret_en,
  input  logic [1:0]          cond_sel,
  input  logic                zero_q,
  input  logic                pari_q,
  input  logic                sc_q,
  input  logic signed [D-1:0] rel_off,
  input  logic [D-1:0]        target,
  output logic [D-1:0]        prog_ctr,
  output logic                run,
  output logic                done,
  output logic                stk_err
);

  localparam logic [D-1:0] START_V = D'(START_PC);

  state_t       state, state_nxt;
  logic [D-1:0] pc_nxt, npc, pc_inc, pc_rel, pop_data;
  logic         err_nxt, stop, cond, push, pop, clr, full, empty;

  // Both adds are modulo 2^D; the offset's sign bits make the wrap work.
  assign pc_inc = prog_ctr + 1'b1;
  assign pc_rel = prog_ctr + rel_off;
  assign cond   = cond_eval(cond_sel, zero_q, pari_q, sc_q);

  ret_stack #(.D(D), .SD(SD)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    err_nxt   = stk_err;
    npc       = pc_inc;
    stop      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = RUN;
          pc_nxt    = START_V;
          clr       = 1'b1;
        end
      end
      RUN: begin
        // halt and stack faults stop with the PC parked where it is.
        if (halt) begin
          stop = 1'b1;
        end else if (ret_en) begin
          if (empty) begin
            stop    = 1'b1;
            err_nxt = 1'b1;
          end else begin
            pop = 1'b1;
            npc = pop_data;
          end
        end else if (call_en && cond) begin
          if (full) begin
            stop    = 1'b1;
            err_nxt = 1'b1;
          end else begin
            push = 1'b1;
            npc  = target;
          end
        end else if (absjump_en && cond) begin
          npc = target;
        end else if (reljump_en && cond) begin
          npc = pc_rel;
        end
        if (stop) begin
          state_nxt = DONE;
        end else begin
          pc_nxt = npc;
          if (32'(npc) == END_PC) state_nxt = DONE;
        end
      end
      DONE: begin
        if (req) begin
          state_nxt = RUN;
          pc_nxt    = START_V;
          err_nxt   = 1'b0;
          clr       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      prog_ctr <= START_V;
      stk_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
      stk_err  <= err_nxt;
    end
  end

  assign run  = (state == RUN);
  assign done = (state == DONE);

endmodule
